// File: rtl/rv64_pkg.sv
// Shared RV64 constants used to size the integer register file.
package rv64_pkg;
  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set when a producer is issued, cleared when it writes back.
module regfile_scoreboard #(
  parameter int RF_SIZE = 5,
  parameter int NUM_WR  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_WR-1:0]         wr_en,
  input  logic [NUM_WR*RF_SIZE-1:0] wr_addr,
  input  logic                      issue_en,
  input  logic [RF_SIZE-1:0]        issue_rd,
  output logic [2**RF_SIZE-1:0]     busy,
  output logic [2**RF_SIZE-1:0]     busy_next
);

  always_comb begin
    busy_next = busy;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en[p]) busy_next[wr_addr[p*RF_SIZE +: RF_SIZE]] = 1'b0;
    end
    // A newly issued producer supersedes a write-back landing in the same cycle.
    if (issue_en) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with x0 hardwired to zero, optional write-to-read
// forwarding and a busy scoreboard; read data and busy flags are registered.
module regfile_mp
  import rv64_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int RF_SIZE    = REG_ADDR_W,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*RF_SIZE-1:0]    rd_addr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o,
  output logic [NUM_RD-1:0]            rd_busy_o,
  input  logic [NUM_WR-1:0]            wr_en_i,
  input  logic [NUM_WR*RF_SIZE-1:0]    wr_addr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data_i,
  input  logic                         issue_en_i,
  input  logic [RF_SIZE-1:0]           issue_rd_i
);

  localparam int DEPTH = 2**RF_SIZE;

  logic [DATA_WIDTH-1:0]         regs [DEPTH];
  logic [DEPTH-1:0]              busy_q;
  logic [DEPTH-1:0]              busy_d;
  logic [NUM_RD*DATA_WIDTH-1:0]  rd_data_d;
  logic [NUM_RD-1:0]             rd_busy_d;

  regfile_scoreboard #(
    .RF_SIZE (RF_SIZE),
    .NUM_WR  (NUM_WR)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en_i),
    .wr_addr   (wr_addr_i),
    .issue_en  (issue_en_i),
    .issue_rd  (issue_rd_i),
    .busy      (busy_q),
    .busy_next (busy_d)
  );

  // Ports are applied in ascending order so the highest-indexed port wins a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en_i[p] && (wr_addr_i[p*RF_SIZE +: RF_SIZE] != '0))
          regs[wr_addr_i[p*RF_SIZE +: RF_SIZE]] <= wr_data_i[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    rd_busy_d = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] = regs[rd_addr_i[k*RF_SIZE +: RF_SIZE]];
      if (BYPASS != 0) begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_en_i[p] && (rd_addr_i[k*RF_SIZE +: RF_SIZE] != '0) &&
              (wr_addr_i[p*RF_SIZE +: RF_SIZE] == rd_addr_i[k*RF_SIZE +: RF_SIZE]))
            rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] = wr_data_i[p*DATA_WIDTH +: DATA_WIDTH];
        end
        rd_busy_d[k] = busy_d[rd_addr_i[k*RF_SIZE +: RF_SIZE]];
      end else begin
        rd_busy_d[k] = busy_q[rd_addr_i[k*RF_SIZE +: RF_SIZE]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_o <= '0;
      rd_busy_o <= '0;
    end else begin
      rd_data_o <= rd_data_d;
      rd_busy_o <= rd_busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance with forwarding, one without, same stimulus.
module tb_regfile_mp;
  localparam int DW = 64;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data_b, rd_data_nb;
  logic [1:0]      rd_busy_b, rd_busy_nb;
  logic [1:0]      wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic            issue_en;
  logic [AW-1:0]   issue_rd;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_WIDTH(DW), .RF_SIZE(AW), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .issue_en_i(issue_en), .issue_rd_i(issue_rd));

  regfile_mp #(.DATA_WIDTH(DW), .RF_SIZE(AW), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb), .rd_busy_o(rd_busy_nb),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .issue_en_i(issue_en), .issue_rd_i(issue_rd));

  task automatic clear_inputs();
    rd_addr  = '0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    issue_en = 1'b0;
    issue_rd = '0;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[p]          = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    set_rd(0, 5'd5);
    step();
    step();
    vectors++;
    if ({rd_data_b, rd_busy_b, rd_data_nb, rd_busy_nb} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got b=%h/%b nb=%h/%b want all zero", rd_data_b, rd_busy_b, rd_data_nb, rd_busy_nb);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (rd_data_b[63:0] !== 64'h0 || rd_busy_b[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_read_x5: got data=%h busy=%b want 0/0", rd_data_b[63:0], rd_busy_b[0]);
    end
  endtask

  task automatic test_write_read();
    clear_inputs();
    set_wr(0, 5'd3, 64'h1234);
    step();
    clear_inputs();
    set_rd(0, 5'd3);
    step();
    vectors++;
    if (rd_data_b[63:0] !== 64'h1234 || rd_data_nb[63:0] !== 64'h1234) begin
      miscompares++;
      $display("FAIL write_read_x3: got b=%h nb=%h want 1234", rd_data_b[63:0], rd_data_nb[63:0]);
    end
  endtask

  task automatic test_same_addr();
    clear_inputs();
    set_wr(0, 5'd7, 64'hAA);
    set_wr(1, 5'd7, 64'hBB);
    step();
    clear_inputs();
    set_rd(1, 5'd7);
    step();
    vectors++;
    if (rd_data_b[127:64] !== 64'hBB || rd_data_nb[127:64] !== 64'hBB) begin
      miscompares++;
      $display("FAIL collide_x7: got b=%h nb=%h want bb", rd_data_b[127:64], rd_data_nb[127:64]);
    end
  endtask

  task automatic test_bypass();
    clear_inputs();
    set_wr(0, 5'd9, 64'h11);
    step();
    clear_inputs();
    set_wr(0, 5'd9, 64'h55);
    set_rd(0, 5'd9);
    step();
    vectors++;
    if (rd_data_b[63:0] !== 64'h55) begin
      miscompares++;
      $display("FAIL bypass_on_x9: got %h want 55", rd_data_b[63:0]);
    end
    vectors++;
    if (rd_data_nb[63:0] !== 64'h11) begin
      miscompares++;
      $display("FAIL bypass_off_x9: got %h want 11", rd_data_nb[63:0]);
    end
    clear_inputs();
    set_rd(0, 5'd9);
    step();
    vectors++;
    if (rd_data_b[63:0] !== 64'h55 || rd_data_nb[63:0] !== 64'h55) begin
      miscompares++;
      $display("FAIL after_write_x9: got b=%h nb=%h want 55", rd_data_b[63:0], rd_data_nb[63:0]);
    end
  endtask

  task automatic test_busy();
    clear_inputs();
    issue_en = 1'b1;
    issue_rd = 5'd4;
    set_rd(0, 5'd4);
    step();
    vectors++;
    if (rd_busy_b[0] !== 1'b1 || rd_busy_nb[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_issue_same: got b=%b nb=%b want 1/0", rd_busy_b[0], rd_busy_nb[0]);
    end
    clear_inputs();
    set_rd(0, 5'd4);
    step();
    vectors++;
    if (rd_busy_b[0] !== 1'b1 || rd_busy_nb[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_issue: got b=%b nb=%b want 1/1", rd_busy_b[0], rd_busy_nb[0]);
    end
    clear_inputs();
    set_wr(0, 5'd4, 64'h44);
    issue_en = 1'b1;
    issue_rd = 5'd4;
    set_rd(0, 5'd4);
    step();
    vectors++;
    if (rd_busy_b[0] !== 1'b1 || rd_busy_nb[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_write_and_issue: got b=%b nb=%b want 1/1", rd_busy_b[0], rd_busy_nb[0]);
    end
    clear_inputs();
    set_wr(1, 5'd4, 64'h45);
    set_rd(0, 5'd4);
    step();
    vectors++;
    if (rd_busy_b[0] !== 1'b0 || rd_busy_nb[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_write_clear: got b=%b nb=%b want 0/1", rd_busy_b[0], rd_busy_nb[0]);
    end
    clear_inputs();
    set_rd(0, 5'd4);
    step();
    vectors++;
    if (rd_busy_b[0] !== 1'b0 || rd_busy_nb[0] !== 1'b0 || rd_data_b[63:0] !== 64'h45) begin
      miscompares++;
      $display("FAIL busy_cleared: got b=%b nb=%b data=%h want 0/0/45", rd_busy_b[0], rd_busy_nb[0], rd_data_b[63:0]);
    end
  endtask

  task automatic test_zero();
    clear_inputs();
    set_wr(0, 5'd0, 64'hFFFF);
    issue_en = 1'b1;
    issue_rd = 5'd0;
    set_rd(0, 5'd0);
    set_rd(1, 5'd0);
    step();
    vectors++;
    if ({rd_data_b, rd_busy_b, rd_data_nb, rd_busy_nb} !== '0) begin
      miscompares++;
      $display("FAIL x0_same_cycle: got b=%h/%b nb=%h/%b want zero", rd_data_b, rd_busy_b, rd_data_nb, rd_busy_nb);
    end
    clear_inputs();
    set_rd(0, 5'd0);
    step();
    vectors++;
    if (rd_data_b[63:0] !== 64'h0 || rd_busy_b[0] !== 1'b0 || rd_data_nb[63:0] !== 64'h0 || rd_busy_nb[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_later: got b=%h/%b nb=%h/%b want 0/0", rd_data_b[63:0], rd_busy_b[0], rd_data_nb[63:0], rd_busy_nb[0]);
    end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    set_wr(0, 5'd11, 64'hA1);
    set_wr(1, 5'd12, 64'hB2);
    step();
    clear_inputs();
    set_wr(0, 5'd13, 64'hC3);
    set_rd(0, 5'd11);
    set_rd(1, 5'd12);
    step();
    vectors++;
    if (rd_data_b !== {64'hB2, 64'hA1} || rd_data_nb !== {64'hB2, 64'hA1}) begin
      miscompares++;
      $display("FAIL b2b_first: got b=%h nb=%h want b2/a1", rd_data_b, rd_data_nb);
    end
    clear_inputs();
    set_wr(1, 5'd11, 64'hD4);
    set_rd(0, 5'd13);
    set_rd(1, 5'd11);
    step();
    vectors++;
    if (rd_data_b !== {64'hD4, 64'hC3} || rd_data_nb !== {64'hA1, 64'hC3}) begin
      miscompares++;
      $display("FAIL b2b_second: got b=%h nb=%h want d4/c3 and a1/c3", rd_data_b, rd_data_nb);
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    set_wr(0, 5'd20, 64'h99);
    issue_en = 1'b1;
    issue_rd = 5'd21;
    step();
    clear_inputs();
    set_rd(0, 5'd20);
    set_rd(1, 5'd21);
    step();
    vectors++;
    if (rd_data_b[63:0] !== 64'h99 || rd_busy_b[1] !== 1'b1 || rd_busy_nb[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: got data=%h busy b=%b nb=%b want 99/1/1", rd_data_b[63:0], rd_busy_b[1], rd_busy_nb[1]);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({rd_data_b, rd_busy_b, rd_data_nb, rd_busy_nb} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got b=%h/%b nb=%h/%b want zero", rd_data_b, rd_busy_b, rd_data_nb, rd_busy_nb);
    end
    set_wr(0, 5'd22, 64'hAB);
    issue_en = 1'b1;
    issue_rd = 5'd23;
    step();
    rst = 1'b0;
    clear_inputs();
    set_rd(0, 5'd22);
    set_rd(1, 5'd20);
    step();
    vectors++;
    if (rd_data_b !== '0 || rd_data_nb !== '0) begin
      miscompares++;
      $display("FAIL post_reset_data: got b=%h nb=%h want zero", rd_data_b, rd_data_nb);
    end
    clear_inputs();
    set_rd(0, 5'd23);
    set_rd(1, 5'd21);
    set_wr(0, 5'd3, 64'h77);
    step();
    vectors++;
    if (rd_busy_b !== 2'b00 || rd_busy_nb !== 2'b00) begin
      miscompares++;
      $display("FAIL post_reset_busy: got b=%b nb=%b want 00", rd_busy_b, rd_busy_nb);
    end
    clear_inputs();
    set_rd(0, 5'd3);
    step();
    vectors++;
    if (rd_data_b[63:0] !== 64'h77 || rd_data_nb[63:0] !== 64'h77) begin
      miscompares++;
      $display("FAIL first_write_after_reset: got b=%h nb=%h want 77", rd_data_b[63:0], rd_data_nb[63:0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_write_read();
    test_same_addr();
    test_bypass();
    test_busy();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
